blend_frame_sequencer: RTL and testbench
========================================

// Module: blend_frame_sequencer
// PURPOSE
//  Sequences one full-frame blend of an original and a sharpened 8-bit image held in two
//  frame-buffer RAMs. Generates the shared linear read address and applies the selected
//  per-pixel blend op. Streams results to an output write port with valid/ready backpressure.
//  Sits between the sharpening stage's buffers and the output frame buffer; a start/done handshake
//  is issued by the top-level image controller.
// PARAMETERS
//  ROWS     512                       frame height in pixels (>=1)
//  COLS     512                       frame width in pixels (>=1)
//  RD_LAT   2                         fixed RAM read latency in cycles, 1..4
//  ADDR_W   $clog2(ROWS*COLS) (min 1) linear pixel address width (derived, localparam)
// PORTS
//  clk          in   1       clock
//  reset        in   1       asynchronous, active-high reset
//  start        in   1       begin a frame; sampled only in IDLE
//  abort        in   1       cancel current frame; sampled in RUN/DRAIN
//  mode         in   2       blend op, latched on accepted start
//  busy         out  1       high from accepted start until return to IDLE
//  done         out  1       one-cycle pulse after last pixel written (not on abort)
//  rd_en        out  1       read strobe to both RAMs (same address)
//  rd_addr      out  ADDR_W  linear address row*COLS+col
//  orig_rdata   in   8       original pixel, valid RD_LAT cycles after rd_en
//  sharp_rdata  in   8       sharpened pixel, valid RD_LAT cycles after rd_en
//  wr_valid     out  1       result available
//  wr_addr      out  ADDR_W  linear address of wr_data
//  wr_data      out  8       blended pixel
//  wr_ready     in   1       sink accepts when wr_valid&&wr_ready
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE; all outputs 0; counters/credits/FIFO cleared; mode=00.
//  Reads in flight at reset are discarded.
//  FSM:
//   IDLE->RUN on start. start while not IDLE is ignored.
//   RUN->DRAIN after read issue of address ROWS*COLS-1.
//   DRAIN->DONE on handshake of write address ROWS*COLS-1.
//   DONE->IDLE unconditionally; done=1 only in DONE.
//   Abort in RUN/DRAIN->FLUSH: no more reads. In-flight returns and FIFO contents are dropped.
//   wr_valid is forced 0. FLUSH->IDLE when the in-flight count reaches 0. No done pulse.
//  Modes (9-bit intermediate, s=orig+sharp):
//   00 = saturating add, min(s,255)
//   01 = average, s>>1 (floor)
//   10 = |orig-sharp|
//   11 = pass sharp
//  Read issue: rd_en=1 in RUN only when credits>0. credits = FIFO_DEPTH - (FIFO occupancy + reads in flight).
//  FIFO_DEPTH = RD_LAT+2. The FIFO never overflows; returned data is always accepted.
//  rd_addr increments by 1 per issued read, starting at 0.
//  Returned data is blended in its return cycle and pushed into the skid FIFO.
//  FIFO head drives wr_data/wr_valid. wr_addr counter starts at 0 and increments per handshake.
//  wr_valid/wr_data/wr_addr hold stable while wr_valid&&!wr_ready.
//  Timing (wr_ready=1): start high in cycle 0 gives first rd_en in cycle 1 and first wr_valid in
//  cycle RD_LAT+2. Throughput is 1 pixel/cycle. done in cycle ROWS*COLS+RD_LAT+2.
//  Simultaneous FIFO push+pop when full or empty are both legal. Occupancy is unchanged when both occur.
//  ROWS*COLS==1: RUN lasts one cycle and goes directly to DRAIN.
// STRUCTURE
//  blend_pkg contains:
//   blend_mode_e enum {BLEND_ADD, BLEND_AVG, BLEND_ABSDIFF, BLEND_PASS}
//   state enum {IDLE, RUN, DRAIN, DONE, FLUSH}
//   function blend_pixel(mode, orig, sharp) -> 8b
//  Sub-module blend_skid_fifo: synchronous FIFO, width 8, depth param, push/pop/full/empty/count,
//  with async reset and a sync flush input.
//  Top contains the FSM, address counters, credit counter and RD_LAT-deep valid shift register.
// TESTING
//  ROWS=COLS=4, RD_LAT=2, mode=00, wr_ready=1, orig=200, sharp=100 -> all 16 wr_data=255.
//   wr_addr 0..15 in order, done in cycle 20.
//  mode=01, orig=7, sharp=4 -> 5. mode=10, orig=3, sharp=10 -> 7. mode=11 -> wr_data=sharp.
//   Mode change mid-frame has no effect.
//  Random wr_ready (50%): no loss/duplication, wr_* stable while stalled,
//   rd_en never issued with credits=0, FIFO never overflows.
//  abort 3 cycles after start -> wr_valid drops next cycle. IDLE after in-flight reads drain.
//   No done pulse. A new start then produces the full frame from address 0.
//  reset asserted mid-RUN -> outputs 0 immediately. Stale RAM returns are ignored.
//   A next frame runs correctly.
//  ROWS=COLS=1 and RD_LAT=1,4 -> a single write at addr 0. done latency = 1+RD_LAT+2.
//   start during busy is ignored.

Source files
------------

// File: rtl/blend_pkg.sv
// Shared types and the per-pixel blend operator for the frame blend sequencer.
package blend_pkg;

  typedef enum logic [1:0] {
    BLEND_ADD,
    BLEND_AVG,
    BLEND_ABSDIFF,
    BLEND_PASS
  } blend_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE,
    FLUSH
  } state_e;

  function automatic logic [7:0] blend_pixel(
    input blend_mode_e mode,
    input logic [7:0]  orig,
    input logic [7:0]  sharp
  );
    logic [8:0] s;
    logic [7:0] r;
    s = {1'b0, orig} + {1'b0, sharp};
    r = '0;
    unique case (mode)
      BLEND_ADD:     r = s[8] ? 8'hff : s[7:0];
      BLEND_AVG:     r = s[8:1];
      BLEND_ABSDIFF: r = (orig >= sharp) ? (orig - sharp)
                                         : (sharp - orig);
      BLEND_PASS:    r = sharp;
      default:       r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/blend_skid_fifo.sv
// Small synchronous skid FIFO; push and pop in the same cycle are
// accepted even when full, since the pop frees the slot being written.
module blend_skid_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rptr_q, wptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= inc(wptr_q);
      end
      if (do_pop) rptr_q <= inc(rptr_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/blend_frame_sequencer.sv
// Streams one frame of blended pixels from two frame-buffer RAMs to a
// valid/ready write port, with credit-based read issue into a skid FIFO.
module blend_frame_sequencer
  import blend_pkg::*;
#(
  parameter  int ROWS   = 512,
  parameter  int COLS   = 512,
  parameter  int RD_LAT = 2,
  localparam int NPIX   = ROWS * COLS,
  localparam int ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        orig_rdata,
  input  logic [7:0]        sharp_rdata,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ready
);

  localparam int FIFO_DEPTH = RD_LAT + 2;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

  state_e            state_q, state_d;
  blend_mode_e       mode_q, mode_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CW-1:0]     infl_q, infl_d;
  logic [RD_LAT-1:0] vld_q, vld_d;

  logic          ret_valid, credit_ok;
  logic          push, pop, flush;
  logic [7:0]    blended, f_dout;
  logic          f_full, f_empty;
  logic [CW-1:0] f_count;

  assign ret_valid = vld_q[RD_LAT-1];
  assign credit_ok = !f_full &&
    (({1'b0, f_count} + {1'b0, infl_q}) < (CW + 1)'(FIFO_DEPTH));

  assign rd_en    = (state_q == RUN) && credit_ok;
  assign rd_addr  = rd_addr_q;
  assign wr_valid = !f_empty && (state_q != FLUSH);
  assign wr_addr  = wr_addr_q;
  assign wr_data  = f_dout;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  // Returns that land after an abort are counted but never stored.
  assign push    = ret_valid && (state_q != FLUSH);
  assign pop     = wr_valid && wr_ready;
  assign flush   = (state_q == FLUSH);
  assign blended = blend_pixel(mode_q, orig_rdata, sharp_rdata);

  blend_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (blended),
    .dout_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_count)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN: begin
        if (abort) state_d = FLUSH;
        else if (rd_en && rd_addr_q == LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (abort) state_d = FLUSH;
        else if (pop && wr_addr_q == LAST) state_d = DONE;
      end
      DONE:  state_d = IDLE;
      FLUSH: if (infl_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mode_d    = mode_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    if (state_q == IDLE) begin
      rd_addr_d = '0;
      wr_addr_d = '0;
      if (start) mode_d = blend_mode_e'(mode);
    end else begin
      if (rd_en) rd_addr_d = rd_addr_q + ADDR_W'(1);
      if (pop)   wr_addr_d = wr_addr_q + ADDR_W'(1);
    end
    infl_d = infl_q + CW'(rd_en) - CW'(ret_valid);
    vld_d  = RD_LAT'({vld_q, rd_en});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= BLEND_ADD;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      infl_q    <= '0;
      vld_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      infl_q    <= infl_d;
      vld_q     <= vld_d;
    end
  end

endmodule

// File: tb/tb_blend_frame_sequencer.sv
// Directed bench: 4x4 frame at RD_LAT=2, plus 1x1 frames at RD_LAT=1 and 4.
module tb_blend_frame_sequencer;

  int n_tests = 0;
  int n_fail  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_a, abort_a, wr_ready_a;
  logic [1:0] mode_a;
  logic       busy_a, done_a, rd_en_a, wr_valid_a;
  logic [3:0] rd_addr_a, wr_addr_a;
  logic [7:0] orig_a, sharp_a, wr_data_a;

  logic       start_s, abort_s, wr_ready_s;
  logic [1:0] mode_s;
  logic [7:0] orig_s, sharp_s;
  logic       busy_b, done_b, rd_en_b, wr_valid_b;
  logic [0:0] rd_addr_b, wr_addr_b;
  logic [7:0] wr_data_b;
  logic       busy_c, done_c, rd_en_c, wr_valid_c;
  logic [0:0] rd_addr_c, wr_addr_c;
  logic [7:0] wr_data_c;

  blend_frame_sequencer #(.ROWS(4), .COLS(4), .RD_LAT(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
    .mode(mode_a), .busy(busy_a), .done(done_a), .rd_en(rd_en_a),
    .rd_addr(rd_addr_a), .orig_rdata(orig_a), .sharp_rdata(sharp_a),
    .wr_valid(wr_valid_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .wr_ready(wr_ready_a)
  );

  blend_frame_sequencer #(.ROWS(1), .COLS(1), .RD_LAT(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_s), .abort(abort_s),
    .mode(mode_s), .busy(busy_b), .done(done_b), .rd_en(rd_en_b),
    .rd_addr(rd_addr_b), .orig_rdata(orig_s), .sharp_rdata(sharp_s),
    .wr_valid(wr_valid_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .wr_ready(wr_ready_s)
  );

  blend_frame_sequencer #(.ROWS(1), .COLS(1), .RD_LAT(4)) dut_c (
    .clk(clk), .reset(reset), .start(start_s), .abort(abort_s),
    .mode(mode_s), .busy(busy_c), .done(done_c), .rd_en(rd_en_c),
    .rd_addr(rd_addr_c), .orig_rdata(orig_s), .sharp_rdata(sharp_s),
    .wr_valid(wr_valid_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
    .wr_ready(wr_ready_s)
  );

  // Two-cycle RAM model for the 4x4 instance; pixel = base + step*addr.
  logic [7:0] o_base, o_step, s_base, s_step;
  logic [3:0] pa0, pa1;

  function automatic logic [7:0] pix(input logic [7:0] b, input logic [7:0] st,
                                     input logic [3:0] a);
    return 8'(int'(b) + int'(st) * int'(a));
  endfunction

  function automatic int ref_blend(input int m, input int o, input int s);
    case (m)
      0: return (o + s > 255) ? 255 : o + s;
      1: return (o + s) / 2;
      2: return (o > s) ? o - s : s - o;
      default: return s;
    endcase
  endfunction

  always @(posedge clk) begin
    pa0 <= rd_addr_a;
    pa1 <= pa0;
  end
  assign orig_a  = pix(o_base, o_step, pa1);
  assign sharp_a = pix(s_base, s_step, pa1);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_pix(input int ob, input int os, input int sb, input int ss);
    o_base = 8'(ob); o_step = 8'(os);
    s_base = 8'(sb); s_step = 8'(ss);
  endtask

  task automatic frame_a(input string tag, input logic [1:0] m, input bit rnd,
                         input int abort_at, input int exp_fix);
    int c, nwr, iss, done_cyc, ndone, exp;
    bit stall;
    logic [7:0] sd;
    logic [3:0] sa;
    c = 0; nwr = 0; iss = 0; done_cyc = -1; ndone = 0;
    stall = 0; sd = '0; sa = '0;
    mode_a = m; start_a = 1'b1; wr_ready_a = 1'b1;
    while (c < 300) begin
      @(negedge clk);
      c++;
      start_a = 1'b0;
      mode_a = ~m;
      abort_a = (c == abort_at);
      wr_ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stall) begin
        chk({tag, " hold valid"}, 32'(wr_valid_a), 32'(1));
        chk({tag, " hold data"}, 32'(wr_data_a), 32'(sd));
        chk({tag, " hold addr"}, 32'(wr_addr_a), 32'(sa));
      end
      if (rd_en_a) begin
        chk({tag, " credit"}, 32'((iss - nwr) < 4), 32'(1));
        chk({tag, " rd_addr"}, 32'(rd_addr_a), 32'(iss % 16));
        iss++;
      end
      if (abort_at > 0 && c > abort_at) begin
        chk({tag, " no valid after abort"}, 32'(wr_valid_a), 32'(0));
        chk({tag, " no read after abort"}, 32'(rd_en_a), 32'(0));
      end
      if (abort_at > 0 && c == abort_at + 2)
        chk({tag, " busy while flushing"}, 32'(busy_a), 32'(1));
      if (wr_valid_a && wr_ready_a) begin
        exp = (exp_fix >= 0) ? exp_fix :
              ref_blend(int'(m), int'(pix(o_base, o_step, 4'(nwr))),
                        int'(pix(s_base, s_step, 4'(nwr))));
        chk({tag, " wr_addr"}, 32'(wr_addr_a), 32'(nwr));
        chk({tag, " wr_data"}, 32'(wr_data_a), 32'(exp));
        nwr++;
      end
      if (done_a) begin
        ndone++;
        done_cyc = c;
      end
      stall = wr_valid_a && !wr_ready_a;
      sd = wr_data_a;
      sa = wr_addr_a;
      if (!busy_a) break;
    end
    abort_a = 1'b0;
    wr_ready_a = 1'b1;
    chk({tag, " back to idle"}, 32'(busy_a), 32'(0));
    if (abort_at > 0) begin
      chk({tag, " no done"}, 32'(ndone), 32'(0));
    end else begin
      chk({tag, " done count"}, 32'(ndone), 32'(1));
      chk({tag, " writes"}, 32'(nwr), 32'(16));
      if (!rnd) chk({tag, " done cycle"}, 32'(done_cyc), 32'(20));
    end
  endtask

  initial begin
    int nb, nc, dbc, dcc;
    reset = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; mode_a = 2'd0; wr_ready_a = 1'b1;
    start_s = 1'b0; abort_s = 1'b0; mode_s = 2'd1; wr_ready_s = 1'b1;
    orig_s = 8'd7; sharp_s = 8'd4;
    set_pix(200, 0, 100, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst busy", 32'(busy_a), 32'(0));
    chk("rst done", 32'(done_a), 32'(0));
    chk("rst rd_en", 32'(rd_en_a), 32'(0));
    chk("rst rd_addr", 32'(rd_addr_a), 32'(0));
    chk("rst wr_valid", 32'(wr_valid_a), 32'(0));
    chk("rst wr_addr", 32'(wr_addr_a), 32'(0));
    chk("rst wr_data", 32'(wr_data_a), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    frame_a("add", 2'd0, 1'b0, 0, 255);
    set_pix(7, 0, 4, 0);
    frame_a("avg", 2'd1, 1'b0, 0, 5);
    set_pix(3, 0, 10, 0);
    frame_a("absdiff", 2'd2, 1'b0, 0, 7);
    set_pix(10, 3, 50, 17);
    frame_a("pass", 2'd3, 1'b0, 0, -1);
    set_pix(90, 13, 40, 29);
    frame_a("random ready", 2'd2, 1'b1, 0, -1);
    frame_a("abort", 2'd0, 1'b0, 3, -1);
    set_pix(120, 11, 200, 7);
    frame_a("after abort", 2'd1, 1'b0, 0, -1);

    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst busy", 32'(busy_a), 32'(0));
    chk("midrst rd_en", 32'(rd_en_a), 32'(0));
    chk("midrst rd_addr", 32'(rd_addr_a), 32'(0));
    chk("midrst wr_valid", 32'(wr_valid_a), 32'(0));
    chk("midrst wr_addr", 32'(wr_addr_a), 32'(0));
    chk("midrst wr_data", 32'(wr_data_a), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    set_pix(33, 5, 250, 9);
    frame_a("after reset", 2'd0, 1'b0, 0, -1);

    nb = 0; nc = 0; dbc = -1; dcc = -1;
    start_s = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start_s = (c == 2) || (c == 4);
      #1;
      if (wr_valid_b) begin
        chk("1x1 lat1 wr_addr", 32'(wr_addr_b), 32'(0));
        chk("1x1 lat1 wr_data", 32'(wr_data_b), 32'(5));
        nb++;
      end
      if (wr_valid_c) begin
        chk("1x1 lat4 wr_addr", 32'(wr_addr_c), 32'(0));
        chk("1x1 lat4 wr_data", 32'(wr_data_c), 32'(5));
        nc++;
      end
      if (done_b) dbc = c;
      if (done_c) dcc = c;
    end
    start_s = 1'b0;
    chk("1x1 lat1 writes", 32'(nb), 32'(1));
    chk("1x1 lat4 writes", 32'(nc), 32'(1));
    chk("1x1 lat1 done cycle", 32'(dbc), 32'(4));
    chk("1x1 lat4 done cycle", 32'(dcc), 32'(7));
    chk("1x1 lat1 idle", 32'(busy_b), 32'(0));
    chk("1x1 lat4 idle", 32'(busy_c), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
